// File: rtl/flash_pack_pkg.sv
`default_nettype none
// ============================================================================
// flash_pack_pkg - shared state type and defaults for flash_word_packer | rev 1.0
// ============================================================================
package flash_pack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  localparam int          DEFAULT_ADDR_W   = 23;
  localparam logic [22:0] DEFAULT_END_ADDR = 23'h7FFFF;

endpackage
`default_nettype wire

// File: rtl/sample_edge_detect.sv
`default_nettype none
// ============================================================================
// sample_edge_detect - one-cycle rising-edge pulse of the sample-rate level | rev 1.0
// ============================================================================
module sample_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/flash_word_packer.sv
`default_nettype none
// ============================================================================
// flash_word_packer - packs 8-bit samples into 32-bit flash words and writes them
// Option: FLASH_PACK_WRAP_EN wraps the address at END_ADDR instead of stopping | rev 1.0
// ============================================================================
module flash_word_packer
  import flash_pack_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(DEFAULT_END_ADDR)
) (
  input  logic              CLK_50M,
  input  logic              reset,
  input  logic              clock_22kHz,
  input  logic              record,
  input  logic [7:0]        data_in,
  input  logic              waitrequest,
  output logic              write_mem,
  output logic [ADDR_W-1:0] addr_out,
  output logic [31:0]       data_out,
  output logic              finished,
  output logic              overrun,
  output logic              busy
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [31:0]       r_pack;
  logic [31:0]       w_pack_nxt;
  logic [31:0]       w_lane_pack;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_finished;
  logic              w_finished_nxt;
  logic              r_overrun;
  logic              w_overrun_nxt;
  logic              r_seen_low;
  logic              w_seen_low_nxt;
  logic              w_last_lane;
  logic              w_continue;
  logic              w_rise;

  sample_edge_detect u_edge (
    .clk     (CLK_50M),
    .rst     (reset),
    .i_level (clock_22kHz),
    .o_rise  (w_rise)
  );

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_lane_pack                  = r_pack;
    w_lane_pack[8*r_idx +: 8]    = data_in;
  end

  assign w_last_lane = (r_idx == IDX_W'(BYTES_PER_WORD - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_pack_nxt     = r_pack;
    w_addr_nxt     = r_addr;
    w_overrun_nxt  = r_overrun;
    w_seen_low_nxt = r_seen_low;
    w_continue     = 1'b1;
`ifdef FLASH_PACK_WRAP_EN
    w_finished_nxt = 1'b0;
`else
    w_finished_nxt = r_finished;
`endif

    case (r_state)
      ST_IDLE: begin
        if (record) begin
          w_state_nxt = ST_COLLECT;
          w_idx_nxt   = '0;
          w_pack_nxt  = '0;
        end
      end

      ST_COLLECT: begin
        // A sample edge wins over a falling record; the flush waits for an edge-free cycle.
        if (w_rise) begin
          w_pack_nxt = w_lane_pack;
          w_idx_nxt  = r_idx + 1'b1;
          if (w_last_lane) begin
            w_state_nxt = ST_WRITE;
          end
        end else if (!record) begin
          w_state_nxt = (r_idx != '0) ? ST_WRITE : ST_IDLE;
        end
      end

      ST_WRITE: begin
        if (w_rise) begin
          w_overrun_nxt = 1'b1;
        end
        if (!waitrequest) begin
          w_state_nxt = ST_ADVANCE;
        end
      end

      ST_ADVANCE: begin
        if (r_addr == END_ADDR) begin
`ifdef FLASH_PACK_WRAP_EN
          w_addr_nxt     = '0;
          w_finished_nxt = 1'b1;
`else
          w_continue     = 1'b0;
          w_state_nxt    = ST_DONE;
          w_finished_nxt = 1'b1;
          w_seen_low_nxt = 1'b0;
`endif
        end else begin
          w_addr_nxt = r_addr + 1'b1;
        end

        if (w_continue) begin
          w_idx_nxt  = '0;
          w_pack_nxt = '0;
          if (record) begin
            w_state_nxt = ST_COLLECT;
            // An edge landing here already belongs to the next word.
            if (w_rise) begin
              w_pack_nxt = {24'h0, data_in};
              w_idx_nxt  = IDX_W'(1);
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      ST_DONE: begin
        if (!record) begin
          w_seen_low_nxt = 1'b1;
        end else if (r_seen_low) begin
          w_state_nxt    = ST_COLLECT;
          w_finished_nxt = 1'b0;
          w_overrun_nxt  = 1'b0;
          w_addr_nxt     = '0;
          w_idx_nxt      = '0;
          w_pack_nxt     = '0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      r_idx      <= '0;
      r_pack     <= '0;
      r_addr     <= '0;
      r_finished <= 1'b0;
      r_overrun  <= 1'b0;
      r_seen_low <= 1'b0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_pack     <= w_pack_nxt;
      r_addr     <= w_addr_nxt;
      r_finished <= w_finished_nxt;
      r_overrun  <= w_overrun_nxt;
      r_seen_low <= w_seen_low_nxt;
    end
  end

  assign write_mem = (r_state == ST_WRITE);
  assign busy      = (r_state == ST_COLLECT) || (r_state == ST_WRITE) || (r_state == ST_ADVANCE);
  assign addr_out  = r_addr;
  assign data_out  = r_pack;
  assign finished  = r_finished;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_flash_word_packer.sv
`default_nettype none
// ============================================================================
// tb_flash_word_packer - directed and random checks against a word-level model | rev 1.0
// ============================================================================
module tb_flash_word_packer;

  localparam int             AW    = 23;
  localparam logic [AW-1:0]  END_A = 23'd3;

  logic          clk = 1'b0;
  logic          reset, clock_22kHz, record, waitrequest;
  logic [7:0]    data_in;
  logic          write_mem, finished, overrun, busy;
  logic [AW-1:0] addr_out;
  logic [31:0]   data_out;

  always #5 clk = ~clk;

  flash_word_packer #(.ADDR_W(AW), .END_ADDR(END_A)) dut (
    .CLK_50M     (clk),
    .reset       (reset),
    .clock_22kHz (clock_22kHz),
    .record      (record),
    .data_in     (data_in),
    .waitrequest (waitrequest),
    .write_mem   (write_mem),
    .addr_out    (addr_out),
    .data_out    (data_out),
    .finished    (finished),
    .overrun     (overrun),
    .busy        (busy)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level reference: bytes gathered in a queue, one outstanding word at a time.
  localparam int P_IDLE = 0, P_GATHER = 1, P_FLASH = 2, P_STEP = 3, P_STOP = 4;
  int            ph = P_IDLE;
  logic [7:0]    q[$];
  logic [31:0]   m_word = '0;
  logic [AW-1:0] m_addr = '0;
  bit            m_fin = 0, m_ovr = 0, m_prev = 0, m_lowseen = 0;

  function automatic logic [31:0] pack_q();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < q.size(); i++) w = w | (32'(q[i]) << (8 * i));
    return w;
  endfunction

  always @(posedge clk) begin : model
    bit rise, cont;
    rise   = clock_22kHz && !m_prev;
    m_prev = clock_22kHz;
    if (reset) begin
      ph = P_IDLE; q.delete(); m_word = '0; m_addr = '0;
      m_fin = 0; m_ovr = 0; m_prev = 0; m_lowseen = 0;
    end else begin
`ifdef FLASH_PACK_WRAP_EN
      m_fin = 0;
`endif
      case (ph)
        P_IDLE: if (record) begin ph = P_GATHER; q.delete(); end
        P_GATHER: begin
          if (rise) begin
            q.push_back(data_in);
            if (q.size() == 4) begin m_word = pack_q(); ph = P_FLASH; end
          end else if (!record) begin
            if (q.size() > 0) begin m_word = pack_q(); ph = P_FLASH; end
            else ph = P_IDLE;
          end
        end
        P_FLASH: begin
          if (rise) m_ovr = 1;
          if (!waitrequest) ph = P_STEP;
        end
        P_STEP: begin
          cont = 1;
          if (m_addr == END_A) begin
`ifdef FLASH_PACK_WRAP_EN
            m_addr = '0; m_fin = 1;
`else
            cont = 0; ph = P_STOP; m_fin = 1; m_lowseen = 0;
`endif
          end else begin
            m_addr = m_addr + 1;
          end
          if (cont) begin
            q.delete();
            if (record) begin
              ph = P_GATHER;
              if (rise) q.push_back(data_in);
            end else begin
              ph = P_IDLE;
            end
          end
        end
        default: begin
          if (!record) m_lowseen = 1;
          else if (m_lowseen) begin
            ph = P_GATHER; q.delete(); m_fin = 0; m_ovr = 0; m_addr = '0;
          end
        end
      endcase
    end
  end

  // Compare process: outputs after each edge against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("write_mem", write_mem, ph == P_FLASH);
      chk("busy", busy, (ph == P_GATHER) || (ph == P_FLASH) || (ph == P_STEP));
      chk("addr_out", addr_out, m_addr);
      chk("finished", finished, m_fin);
      chk("overrun", overrun, m_ovr);
      if (ph == P_FLASH) chk("data_out", data_out, m_word);
    end
  end

  // Write log: accepted writes and how many cycles each request was held.
  logic [AW-1:0] lg_addr[$];
  logic [31:0]   lg_data[$];
  int            lg_len[$];
  int            run = 0;
  int            fin_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      run = 0;
    end else begin
      if (finished) fin_cnt++;
      if (write_mem) run++;
      if (write_mem && !waitrequest) begin
        lg_addr.push_back(addr_out);
        lg_data.push_back(data_out);
        lg_len.push_back(run);
        run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic sample(input logic [7:0] b);
    clock_22kHz = 1'b1;
    data_in     = b;
    tick();
    clock_22kHz = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; record = 1'b0; waitrequest = 1'b0; clock_22kHz = 1'b0; data_in = '0;
    ticks(2);
    reset = 1'b0;
    lg_addr.delete(); lg_data.delete(); lg_len.delete(); fin_cnt = 0;
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [AW-1:0] a, input logic [31:0] d);
    if (lg_data.size() > idx) begin
      chk({nm, "_addr"}, lg_addr[idx], a);
      chk({nm, "_data"}, lg_data[idx], d);
    end else begin
      chk({nm, "_present"}, 32'(lg_data.size()), 32'(idx + 1));
    end
  endtask

  int hp;

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("rst_write_mem", write_mem, 1'b0);
    chk("rst_addr", addr_out, '0);
    chk("rst_data", data_out, '0);
    chk("rst_finished", finished, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // Four bytes, no wait states.
    record = 1'b1; tick();
    sample(8'h11); sample(8'h22); sample(8'h33); sample(8'h44);
    ticks(4);
    chk("t1_count", 32'(lg_data.size()), 32'd1);
    chk_log("t1", 0, '0, 32'h44332211);
    if (lg_len.size() > 0) chk("t1_len", 32'(lg_len[0]), 32'd1);
    chk("t1_addr_after", addr_out, 23'd1);

    // Five wait-state cycles.
    do_reset();
    record = 1'b1; waitrequest = 1'b1; tick();
    sample(8'h11); sample(8'h22); sample(8'h33); sample(8'h44);
    ticks(4);
    waitrequest = 1'b0;
    ticks(4);
    chk("t2_count", 32'(lg_data.size()), 32'd1);
    chk_log("t2", 0, '0, 32'h44332211);
    if (lg_len.size() > 0) chk("t2_len", 32'(lg_len[0]), 32'd6);

    // Flush of a partial word.
    do_reset();
    record = 1'b1; tick();
    sample(8'hAA); sample(8'hBB);
    record = 1'b0;
    ticks(5);
    chk("t3_count", 32'(lg_data.size()), 32'd1);
    chk_log("t3", 0, '0, 32'h0000BBAA);
    chk("t3_busy", busy, 1'b0);

    // Edge during a stalled write.
    do_reset();
    record = 1'b1; waitrequest = 1'b1; tick();
    sample(8'hC1); sample(8'hC2); sample(8'hC3); sample(8'hC4);
    sample(8'h5A);
    chk("t4_overrun", overrun, 1'b1);
    waitrequest = 1'b0;
    ticks(3);
    sample(8'h01); sample(8'h02); sample(8'h03); sample(8'h04);
    ticks(4);
    chk("t4_overrun_sticky", overrun, 1'b1);
    chk("t4_count", 32'(lg_data.size()), 32'd2);
    chk_log("t4a", 0, '0, 32'hC4C3C2C1);
    chk_log("t4b", 1, 23'd1, 32'h04030201);

    // Run to the end of the region.
    do_reset();
    record = 1'b1; tick();
    for (int i = 0; i < 20; i++) sample(8'(8'h10 + i));
    ticks(4);
    chk_log("t5_first", 0, '0, 32'h13121110);
    chk_log("t5_last", 3, 23'd3, 32'h1F1E1D1C);
`ifdef FLASH_PACK_WRAP_EN
    chk("t5_count", 32'(lg_data.size()), 32'd5);
    chk_log("t5_wrap", 4, '0, 32'h23222120);
    chk("t5_fin_pulse", 32'(fin_cnt), 32'd1);
`else
    chk("t5_count", 32'(lg_data.size()), 32'd4);
    chk("t5_finished", finished, 1'b1);
    chk("t5_busy", busy, 1'b0);
    record = 1'b0; tick();
    record = 1'b1; ticks(2);
    chk("t5_restart_fin", finished, 1'b0);
    chk("t5_restart_addr", addr_out, '0);
    chk("t5_restart_busy", busy, 1'b1);
`endif

    // Reset while a write is pending.
    do_reset();
    record = 1'b1; waitrequest = 1'b1; tick();
    sample(8'hD1); sample(8'hD2); sample(8'hD3); sample(8'hD4);
    chk("t6_pending", write_mem, 1'b1);
    reset = 1'b1; tick();
    chk("t6_write_mem", write_mem, 1'b0);
    chk("t6_addr", addr_out, '0);
    chk("t6_busy", busy, 1'b0);
    reset = 1'b0; waitrequest = 1'b0;
    lg_addr.delete(); lg_data.delete(); lg_len.delete();
    tick();
    sample(8'h01); sample(8'h02); sample(8'h03); sample(8'h04);
    ticks(4);
    chk("t6_count", 32'(lg_data.size()), 32'd1);
    chk_log("t6", 0, '0, 32'h04030201);

    // Random traffic checked cycle by cycle against the model.
    do_reset();
    hp = 2;
    for (int c = 0; c < 6000; c++) begin
      if (hp == 0) begin
        clock_22kHz = ~clock_22kHz;
        hp = $urandom_range(0, 5);
      end else begin
        hp--;
      end
      data_in = 8'($urandom);
      if ($urandom_range(0, 59) == 0) record = ~record;
      waitrequest = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    reset = 1'b0;
    ticks(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
